// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around the combinational SafeALU: registers operands,
// captures flags one cycle later and hands results downstream on valid/ready.
module alu_issue_ctrl #(
   parameter int W       = 8,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic [1:0]         in_op,
   input  logic               in_use_acc,
   output logic [W-1:0]       alu_a,
   output logic [W-1:0]       alu_b,
   output logic [1:0]         alu_op,
   input  logic [W-1:0]       alu_r,
   input  logic               alu_z,
   input  logic               alu_c,
   input  logic               alu_v,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_r,
   output logic               out_z,
   output logic               out_c,
   output logic               out_v,
   output logic               sticky_c,
   output logic               sticky_v,
   input  logic               sticky_clr,
   output logic [COUNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         alu_a_q, alu_a_d;
   logic [W-1:0]         alu_b_q, alu_b_d;
   logic [1:0]           alu_op_q, alu_op_d;
   logic [W-1:0]         out_r_q, out_r_d;
   logic                 out_z_q, out_z_d;
   logic                 out_c_q, out_c_d;
   logic                 out_v_q, out_v_d;
   logic [W-1:0]         acc_q, acc_d;
   logic                 sticky_c_q, sticky_c_d;
   logic                 sticky_v_q, sticky_v_d;
   logic [COUNT_W-1:0]   op_count_q, op_count_d;
   logic                 in_eval;

   assign in_eval = (state_q == EVAL);

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      out_r_d    = out_r_q;
      out_z_d    = out_z_q;
      out_c_d    = out_c_q;
      out_v_d    = out_v_q;
      acc_d      = acc_q;
      op_count_d = op_count_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               alu_a_d  = in_use_acc ? acc_q : in_a;
               alu_b_d  = in_b;
               alu_op_d = in_op;
               state_d  = EVAL;
            end
         end
         EVAL: begin
            out_r_d    = alu_r;
            out_z_d    = alu_z;
            out_c_d    = alu_c;
            out_v_d    = alu_v;
            acc_d      = alu_r;
            op_count_d = op_count_q + COUNT_W'(1);
            state_d    = RESP;
         end
         RESP: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a capture in the same cycle as a clear still sets the flag
      sticky_c_d = (sticky_clr ? 1'b0 : sticky_c_q) | (in_eval & alu_c);
      sticky_v_d = (sticky_clr ? 1'b0 : sticky_v_q) | (in_eval & alu_v);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         out_r_q    <= '0;
         out_z_q    <= 1'b0;
         out_c_q    <= 1'b0;
         out_v_q    <= 1'b0;
         acc_q      <= '0;
         sticky_c_q <= 1'b0;
         sticky_v_q <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         out_r_q    <= out_r_d;
         out_z_q    <= out_z_d;
         out_c_q    <= out_c_d;
         out_v_q    <= out_v_d;
         acc_q      <= acc_d;
         sticky_c_q <= sticky_c_d;
         sticky_v_q <= sticky_v_d;
         op_count_q <= op_count_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == RESP);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign out_r     = out_r_q;
   assign out_z     = out_z_q;
   assign out_c     = out_c_q;
   assign out_v     = out_v_q;
   assign sticky_c  = sticky_c_q;
   assign sticky_v  = sticky_v_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table plus hand sequences, results
// checked through an expected-result queue; a 4-bit-counter copy checks wrap.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_use_acc, out_ready, sticky_clr;
   logic [7:0] in_a, in_b;
   logic [1:0] in_op;

   logic        in_ready, out_valid, out_z, out_c, out_v;
   logic        sticky_c, sticky_v, alu_z, alu_c, alu_v;
   logic [7:0]  alu_a, alu_b, alu_r, out_r;
   logic [1:0]  alu_op;
   logic [15:0] op_count;

   logic       in_ready4, out_valid4, out_z4, out_c4, out_v4;
   logic       sticky_c4, sticky_v4, alu_z4, alu_c4, alu_v4;
   logic [7:0] alu_a4, alu_b4, alu_r4, out_r4;
   logic [1:0] alu_op4;
   logic [3:0] op_count4;

   always #5 clk = ~clk;

   // reference SafeALU: C is carry for ADD, borrow for SUB
   function automatic logic [10:0] alu_f(input logic [7:0] a, b,
                                         input logic [1:0] op);
      logic [8:0] s;
      logic [7:0] r;
      logic       c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         2'b00: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         2'b01: begin
            r = a - b;
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         2'b10:   r = a & b;
         default: r = a | b;
      endcase
      return {(r == 8'd0), c, v, r};
   endfunction

   always_comb {alu_z, alu_c, alu_v, alu_r} = alu_f(alu_a, alu_b, alu_op);
   always_comb {alu_z4, alu_c4, alu_v4, alu_r4} =
      alu_f(alu_a4, alu_b4, alu_op4);

   alu_issue_ctrl #(.W(8), .COUNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_r(alu_r), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_z(out_z), .out_c(out_c), .out_v(out_v),
      .sticky_c(sticky_c), .sticky_v(sticky_v), .sticky_clr(sticky_clr),
      .op_count(op_count)
   );

   alu_issue_ctrl #(.W(8), .COUNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready4),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
      .alu_r(alu_r4), .alu_z(alu_z4), .alu_c(alu_c4), .alu_v(alu_v4),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_r(out_r4), .out_z(out_z4), .out_c(out_c4), .out_v(out_v4),
      .sticky_c(sticky_c4), .sticky_v(sticky_v4), .sticky_clr(sticky_clr),
      .op_count(op_count4)
   );

   typedef struct {
      logic [7:0] a, b, ea;
      logic [1:0] op;
      logic       ua;
      logic [7:0] r;
      logic       z, c, v;
   } vec_t;

   typedef struct {
      logic [7:0] r;
      logic       z, c, v;
   } res_t;

   res_t        sb[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] exp_cnt = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] ex);
      n_chk++;
      if (act === ex) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, ex);
   endtask

   function automatic vec_t mk(input logic [7:0] a, b, ea,
                               input logic [1:0] op, input logic ua,
                               input logic [7:0] r,
                               input logic z, c, v);
      vec_t t;
      t.a = a; t.b = b; t.ea = ea; t.op = op; t.ua = ua;
      t.r = r; t.z = z; t.c = c; t.v = v;
      return t;
   endfunction

   // drive a request, wait (bounded) for acceptance, record the expectation
   task automatic issue(input string nm, input vec_t t);
      int   n;
      res_t e;
      n = 0;
      in_a = t.a; in_b = t.b; in_op = t.op; in_use_acc = t.ua;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.r = t.r; e.z = t.z; e.c = t.c; e.v = t.v;
      sb.push_back(e);
      chk({nm, "_alu_a"}, {24'd0, alu_a}, {24'd0, t.ea});
      chk({nm, "_alu_op"}, {30'd0, alu_op}, {30'd0, t.op});
   endtask

   task automatic compare_out(input string nm);
      res_t e;
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({nm, "_result"}, {21'd0, out_valid, out_z, out_c, out_v, out_r},
             {21'd0, 1'b1, e.z, e.c, e.v, e.r});
      end
   endtask

   // called in EVAL: checks latency, result, count, then handshakes
   task automatic collect(input string nm, input logic clr_in_eval);
      chk({nm, "_eval_no_valid"}, {31'd0, out_valid}, 32'd0);
      sticky_clr = clr_in_eval;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      compare_out(nm);
      chk({nm, "_count"}, {16'd0, op_count}, {16'd0, exp_cnt});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_handshake"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   task automatic run_op(input string nm, input vec_t t);
      issue(nm, t);
      collect(nm, 1'b0);
   endtask

   vec_t tbl[10];
   vec_t t;
   logic bad;

   initial begin
      tbl[0] = mk(8'd10,  8'd20,  8'd10,  2'b00, 1'b0, 8'd30, 0, 0, 0);
      tbl[1] = mk(8'd200, 8'd100, 8'd200, 2'b00, 1'b0, 8'd44, 0, 1, 0);
      tbl[2] = mk(8'd99,  8'd44,  8'd44,  2'b01, 1'b1, 8'd0,  1, 0, 0);
      tbl[3] = mk(8'hFF,  8'h01,  8'hFF,  2'b00, 1'b0, 8'h00, 1, 1, 0);
      tbl[4] = mk(8'h05,  8'h0A,  8'h05,  2'b01, 1'b0, 8'hFB, 0, 1, 0);
      tbl[5] = mk(8'h80,  8'h01,  8'h80,  2'b01, 1'b0, 8'h7F, 0, 0, 1);
      tbl[6] = mk(8'h7F,  8'h01,  8'h7F,  2'b00, 1'b0, 8'h80, 0, 0, 1);
      tbl[7] = mk(8'hAA,  8'h0F,  8'hAA,  2'b10, 1'b0, 8'h0A, 0, 0, 0);
      tbl[8] = mk(8'h55,  8'h88,  8'h55,  2'b11, 1'b0, 8'hDD, 0, 0, 0);
      tbl[9] = mk(8'h00,  8'h23,  8'hDD,  2'b00, 1'b1, 8'h00, 1, 1, 0);

      rst_n = 1'b0; in_valid = 1'b0; in_use_acc = 1'b0;
      out_ready = 1'b0; sticky_clr = 1'b0;
      in_a = '0; in_b = '0; in_op = '0;
      #12;
      chk("reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
      chk("reset_regs", {alu_a, out_r, 6'd0, sticky_c, sticky_v, 8'd0},
          32'd0);
      chk("reset_count", {16'd0, op_count}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i]);
         if (i == 1) chk("sticky_c_set", {31'd0, sticky_c}, 32'd1);
      end
      chk("sticky_after_tbl", {30'd0, sticky_c, sticky_v}, 32'd3);

      // backpressure with a pending request
      issue("bp", mk(8'h7F, 8'h01, 8'h7F, 2'b00, 1'b0, 8'h80, 0, 0, 1));
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 16'd1;
      in_a = 8'hAA; in_b = 8'h0F; in_op = 2'b10; in_use_acc = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d", i),
             {22'd0, out_valid, in_ready, out_v, out_r},
             {22'd0, 1'b1, 1'b0, 1'b1, 8'h80});
         @(posedge clk); #1;
      end
      chk("bp_alu_held", {24'd0, alu_a}, 32'h7F);
      compare_out("bp");
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", {22'd0, in_ready, out_valid, alu_a},
          {22'd0, 1'b1, 1'b0, 8'h7F});
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back('{r: 8'h0A, z: 1'b0, c: 1'b0, v: 1'b0});
      chk("bp_pending_acc", {22'd0, alu_op, alu_a}, {22'd0, 2'b10, 8'hAA});
      collect("bp_pend", 1'b0);

      // sticky clear: set wins in EVAL, standalone clear wipes
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      chk("sticky_clr0", {30'd0, sticky_c, sticky_v}, 32'd0);
      issue("sv", mk(8'h7F, 8'h01, 8'h7F, 2'b00, 1'b0, 8'h80, 0, 0, 1));
      collect("sv", 1'b1);
      chk("sticky_set_wins", {30'd0, sticky_c, sticky_v}, 32'd1);
      run_op("sc", mk(8'hF0, 8'h20, 8'hF0, 2'b00, 1'b0, 8'h10, 0, 1, 0));
      chk("sticky_both", {30'd0, sticky_c, sticky_v}, 32'd3);
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      chk("sticky_clr1", {30'd0, sticky_c, sticky_v}, 32'd0);

      // reset during EVAL aborts the operation
      run_op("pre_rst", tbl[3]);
      issue("abort", tbl[0]);
      rst_n = 1'b0;
      #1;
      chk("rst_eval_hs", {30'd0, in_ready, out_valid}, 32'd2);
      chk("rst_eval_state", {14'd0, sticky_c, sticky_v, op_count}, 32'd0);
      chk("rst_eval_cnt4", {28'd0, op_count4}, 32'd0);
      sb.delete();
      exp_cnt = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (out_valid || op_count != 16'd0) bad = 1'b1;
      end
      chk("rst_no_result", {31'd0, bad}, 32'd0);

      // accumulator is zero after reset; then 17 ops for counter wrap
      for (int k = 1; k <= 17; k++) begin
         if (k == 1)
            t = mk(8'h63, 8'h05, 8'h00, 2'b00, 1'b1, 8'h05, 0, 0, 0);
         else
            t = mk(8'(k), 8'h01, 8'(k), 2'b00, 1'b0, 8'(k + 1), 0, 0, 0);
         run_op($sformatf("wrap%0d", k), t);
         if (k == 15) chk("cnt4_15", {28'd0, op_count4}, 32'd15);
         if (k == 16) chk("cnt4_16", {28'd0, op_count4}, 32'd0);
         if (k == 17) chk("cnt4_17", {28'd0, op_count4}, 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/capture stage wrapped around the combinational 8-bit SafeALU. It accepts operations over a valid/ready handshake and drives registered operands and an opcode into the ALU. One cycle later it captures R/Z/C/V into an output register and presents them downstream over a second valid/ready handshake. It also keeps an accumulator (last result), sticky carry/overflow flags and a completed-operation counter.

## Interface
- W, 8, datapath width; must equal ALU width.
- COUNT_W, 16, width of op_count.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- in_use_acc  in  1  if 1, the accumulator replaces in_a as operand A.
- alu_a  out  W  registered operand A to ALU.
- alu_b  out  W  registered operand B to ALU.
- alu_op  out  2  registered opcode to ALU.
- alu_r  in  W  ALU result.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry flag.
- alu_v  in  1  ALU overflow flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_r  out  W  captured result.
- out_z  out  1  captured Z flag.
- out_c  out  1  captured C flag.
- out_v  out  1  captured V flag.
- sticky_c  out  1  OR of captured C since last clear.
- sticky_v  out  1  OR of captured V since last clear.
- sticky_clr  in  1  synchronous clear of both sticky flags.
- op_count  out  COUNT_W  completed captures, modulo 2^COUNT_W.

## Operation
- FSM states: IDLE, EVAL, RESP. in_ready = (state==IDLE); out_valid = (state==RESP).
- IDLE: on in_valid at a clock edge:
  - alu_a <= in_use_acc ? acc : in_a; alu_b <= in_b; alu_op <= in_op.
  - Next state EVAL.
- EVAL (exactly one cycle):
  - out_r/z/c/v <= alu_r/z/c/v.
  - acc <= alu_r.
  - op_count <= op_count+1, wrapping to 0.
  - Sticky flags updated.
  - Next state RESP.
- RESP: out_* and alu_* hold. On out_ready, next state IDLE. out_valid drops after that edge.
- Flags pass through unmodified. The ALU alone defines C/V semantics.
- Sticky update each edge: sticky_x <= (sticky_clr ? 0 : sticky_x) | (state==EVAL & alu_x).
  - Set wins over a simultaneous clear.
  - sticky_clr is legal in any state.
- acc is internal and never cleared except by reset. in_use_acc before any capture uses 0.
- in_a/in_b/in_op are ignored outside IDLE. in_valid held high during EVAL/RESP is not accepted, and no request is dropped or duplicated.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - alu_a/alu_b/alu_op, out_r/z/c/v, acc, sticky_c/v and op_count all 0.
  - in_ready=1, out_valid=0.
- Reset mid-EVAL or mid-RESP aborts the operation. No out_valid follows, and op_count is unchanged from its reset value.
- Latency: request accepted at edge N gives out_valid high after edge N+1, with out_* stable from that edge.
- Throughput: minimum 3 cycles per op (accept, EVAL, RESP with out_ready=1). in_ready rises the cycle after the RESP handshake.
- out_valid never de-asserts without a handshake. out_* remain stable while out_valid & !out_ready.
- ALU path: registered alu_* → combinational ALU → captured at the end of EVAL. This gives a full cycle of settle time.

## Test plan
- Reset: assert rst_n=0 during EVAL → immediately out_valid=0, in_ready=1, op_count=0, sticky=0; no result after release.
- Basic ADD: A=10, B=20, op=00 accepted at edge N → out_valid after edge N+1, out_r=30, Z=0, C=0, V=0, op_count=1.
- Accumulator chain:
  - First ADD 200+100 → out_r=44, C=1, sticky_c=1.
  - Then in_use_acc=1, in_a=99 (ignored), B=44, op=01 → alu_a=44, out_r=0, Z=1.
  - sticky_c remains 1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 0x7F+1 → out_r=0x80, V=1 stable throughout; in_ready=0; a pending in_valid is not accepted until one cycle after the handshake.
- Sticky clear:
  - sticky_clr in the same cycle as EVAL of 0x7F+1 → sticky_v=1 afterwards.
  - sticky_clr alone in a later cycle → sticky_v=0, sticky_c=0.
  - AND 0xAA,0x0F → out_r=0x0A; OR 0x55,0x88 → out_r=0xDD.
- Counter wrap: COUNT_W=4, issue 17 ops → op_count reads 15 after op 15, 0 after op 16, 1 after op 17.
